bayer_line_sequencer: RTL and testbench
=======================================

Name: bayer_line_sequencer

Overview:
- Front-end controller for the 2x2 Bayer demosaic stage.
- Takes the raw 12-bit sensor stream (FVAL/LVAL framed) and tracks row and column positions.
- Keeps a one-line delay buffer and drives the demosaic inputs D0 (previous line), D1 (current line), X/Y parity and DVAL.
- Sits between the sensor capture registers and the demosaic stage; also reports frame count and line-overflow status.

Parameters:
- DW, 12, pixel width.
- MAX_WIDTH, 2048, maximum active pixels per line (line-buffer depth).
- AW, 11, line-buffer address width; must satisfy 2^AW >= MAX_WIDTH.

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  reset, asynchronous, active-low.
- iDATA  in  DW  raw Bayer pixel.
- iFVAL  in  1  frame valid.
- iLVAL  in  1  line valid; a pixel is valid when iFVAL & iLVAL.
- iX_PHASE  in  1  column parity of the first pixel; sampled at SOF.
- iY_PHASE  in  1  row parity of the first line; sampled at SOF.
- oD0  out  DW  same-column pixel from the previous line.
- oD1  out  DW  current-line pixel.
- oX  out  1  column parity.
- oY  out  1  row parity.
- oDVAL  out  1  D0/D1/X/Y valid.
- oSOF  out  1  one-cycle pulse on the first valid pixel of a frame.
- oFRAME_CNT  out  16  frames started since reset; wraps 0xFFFF->0.
- oOVF  out  1  sticky: a line exceeded MAX_WIDTH; cleared at the next SOF.

Behaviour:
- Reset values:
  - all outputs 0;
  - state S_SYNC;
  - column and row counters 0;
  - phase registers 0.
- FSM states and transitions:
  - S_SYNC: wait for iFVAL=0, so the block never starts mid-frame; then go to S_WAIT.
  - S_WAIT: on iFVAL rising, latch the phases, row=0, go to S_LINE.
  - S_LINE: each valid pixel increments col. On iLVAL falling, go to S_HBLANK.
  - S_HBLANK: col=0. On iLVAL rising with iFVAL=1, row++ and go to S_LINE. On iFVAL=0, go to S_WAIT.
  - iFVAL falling in S_LINE: go to S_WAIT directly; the partial line is output as received.
- Line buffer:
  - single-port-per-side RAM, depth MAX_WIDTH, 1-cycle registered read;
  - read address = write address = col, read-before-write;
  - iDATA is delayed one stage to align with the RAM read data.
- Output latency: exactly 2 cycles from a valid input pixel to oDVAL=1 with that pixel on oD1.
- Output fields:
  - oD0 = RAM data for that column. On row 0, oD0 is forced to 0, since the buffer holds the previous frame.
  - oX = col[0]^xphase; oY = row[0]^yphase; both pipelined to align with oD1.
  - oDVAL is high only for in-range valid pixels. The demosaic stage applies its own X/Y gating downstream.
- Overflow: when col reaches MAX_WIDTH, further pixels on that line are dropped (no write, no oDVAL), col saturates, and oOVF is set.
- oSOF coincides with oDVAL of pixel (0,0). oFRAME_CNT increments on the same cycle.
- Simultaneous events: if iFVAL and iLVAL rise in the same cycle, the first pixel is accepted that cycle.
- Phase inputs are ignored except at SOF; mid-frame changes have no effect.
- Async reset mid-line: pipeline and counters clear immediately, then resync via S_SYNC. RAM contents are don't-care.

Optional Feature:
- Macro: BAYER_TEST_PATTERN_EN.
- Defined:
  - adds input iTP_SEL;
  - when iTP_SEL=1, iDATA is replaced at pipeline stage 0 by the pattern {row[5:0],col[5:0]};
  - timing, FSM and all framing are unchanged.
- Undefined: no iTP_SEL port; no pattern logic is synthesized.

Decomposition:
- Package bayer_seq_pkg holds:
  - the FSM state enum (S_SYNC, S_WAIT, S_LINE, S_HBLANK);
  - the pipeline latency constant PIPE_LAT=2;
  - the default pixel width.
- Sub-module bayer_line_ram holds the line buffer: simple dual-port, DW x MAX_WIDTH, registered read, read-before-write.

Test Plan:
- Frame 4x4, phases 0, iDATA = 16*row+col:
  - row 0: oD0=0;
  - pixel (2,1): oD1=0x21, oD0=0x11, oX=1, oY=0;
  - each output 2 cycles after its input.
- Phases 1/1 at SOF, toggled to 0/0 mid-frame → pixel (0,0) has oX=1, oY=1, and parity is unaffected by the mid-frame change.
- Start with iFVAL already high mid-frame → no oDVAL until after iFVAL falls and rises again; then oSOF=1 and oFRAME_CNT=1.
- MAX_WIDTH=8, line of 10 pixels → 8 oDVAL pulses, oOVF=1; oOVF clears at the next SOF.
- Assert RST_N=0 mid-line for 1 cycle → all outputs 0 next edge, no oDVAL until a fresh frame; oFRAME_CNT restarts at 1.
- BAYER_TEST_PATTERN_EN with iTP_SEL=1, pixel (3,5) → oD1=0x0C5.

Source files
------------

// File: rtl/bayer_seq_pkg.sv
// ----------------------------------------------------------------------------
// bayer_seq_pkg
// Shared definitions for the Bayer line sequencer:
//   seq_state_t  - framing FSM states
//   PIPE_LAT     - cycles from an accepted input pixel to its oDVAL
//   DEF_DW       - default raw pixel width
//   ROW_W        - row counter width
//   bayer_parity - colour-site parity of a position given the frame phase
// ----------------------------------------------------------------------------
package bayer_seq_pkg;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_WAIT   = 2'd1,
    S_LINE   = 2'd2,
    S_HBLANK = 2'd3
  } seq_state_t;

  // The data path is fixed at RAM read + output register; the sideband
  // shift registers are sized from this so they stay aligned with it.
  localparam int PIPE_LAT = 2;

  localparam int DEF_DW = 12;

  localparam int ROW_W = 12;

  function automatic logic bayer_parity(input logic pos_lsb, input logic phase);
    return pos_lsb ^ phase;
  endfunction

endpackage

// File: rtl/bayer_line_ram.sv
// ----------------------------------------------------------------------------
// bayer_line_ram
// One-line delay buffer: simple dual-port, DW x DEPTH, registered read.
// When read and write hit the same address in one cycle the read returns
// the old contents (read-before-write), which is what yields the previous
// line's pixel for the current column.
// Ports:
//   CLK      pixel clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (sampled every cycle)
//   rd_data  registered read data, one cycle after rd_addr
// ----------------------------------------------------------------------------
module bayer_line_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Contents are not reset; a fresh frame never uses row-0 read data.
  always_ff @(posedge CLK) begin
    rd_data <= mem[rd_addr];
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/bayer_line_sequencer.sv
// ----------------------------------------------------------------------------
// bayer_line_sequencer
// Front end of the 2x2 Bayer demosaic. Tracks row/column of the FVAL/LVAL
// framed sensor stream, keeps a one-line delay buffer, and presents the
// previous-line pixel (oD0) and current-line pixel (oD1) with their colour
// parities two cycles after the pixel arrives.
//
// Build option: define BAYER_TEST_PATTERN_EN to add iTP_SEL, which replaces
// the incoming pixel with {row[5:0], col[5:0]} at the first pipeline stage.
//
// Ports:
//   CLK, RST_N          pixel clock, asynchronous active-low reset
//   iDATA               raw Bayer pixel
//   iFVAL, iLVAL        frame / line valid; pixel valid = iFVAL & iLVAL
//   iX_PHASE, iY_PHASE  parity of first column / first line, taken at SOF
//   iTP_SEL             (test-pattern build only) select generated pattern
//   oD0                 same-column pixel of the previous line (0 on row 0)
//   oD1                 current pixel
//   oX, oY              column / row parity
//   oDVAL               oD0/oD1/oX/oY valid
//   oSOF                pulse with the first pixel of a frame
//   oFRAME_CNT          frames started since reset
//   oOVF                sticky line overflow, cleared at next SOF
// ----------------------------------------------------------------------------
module bayer_line_sequencer
  import bayer_seq_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int MAX_WIDTH = 2048,
  parameter int AW        = 11
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] iDATA,
  input  logic          iFVAL,
  input  logic          iLVAL,
  input  logic          iX_PHASE,
  input  logic          iY_PHASE,
`ifdef BAYER_TEST_PATTERN_EN
  input  logic          iTP_SEL,
`endif
  output logic [DW-1:0] oD0,
  output logic [DW-1:0] oD1,
  output logic          oX,
  output logic          oY,
  output logic          oDVAL,
  output logic          oSOF,
  output logic [15:0]   oFRAME_CNT,
  output logic          oOVF
);

  // Column counter needs one extra bit so it can hold MAX_WIDTH itself,
  // which is where it saturates on an overlong line.
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_WIDTH);

  seq_state_t state_reg, state_next;

  logic [CW-1:0]    col_reg, col_eff;
  logic [ROW_W-1:0] row_reg, row_eff;
  logic             xph_reg, yph_reg, xph_eff, yph_eff;
  logic             sof_pend_reg;
  logic             lval_d_reg;

  logic             accept;     // pixel belongs to a tracked frame
  logic             first_pix;  // first pixel of the frame
  logic             in_range;
  logic             pix_ok;     // accepted and within the line buffer
  logic             ovf_hit;    // accepted but beyond MAX_WIDTH
  logic [DW-1:0]    pix_data;

  // Sideband delay lines; index PIPE_LAT is the output-aligned stage.
  logic [PIPE_LAT:1] dval_pipe_reg;
  logic [PIPE_LAT:1] sof_pipe_reg;
  logic [PIPE_LAT:1] x_pipe_reg;
  logic [PIPE_LAT:1] y_pipe_reg;
  logic              x_in, y_in;

  // Stage 1: aligned with the RAM read data.
  logic [DW-1:0] s1_data_reg;
  logic          s1_row0_reg;
  logic          s1_ovf_reg;
  logic [DW-1:0] ram_rd_data;

  // Stage 2: output registers.
  logic [DW-1:0] d0_reg, d1_reg;
  logic [15:0]   frame_cnt_reg;
  logic          ovf_reg;

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_SYNC;
    end else begin
      state_reg <= state_next;
    end
  end

  // col_eff/row_eff/phase_eff are the position and phases that apply to the
  // pixel on the inputs this cycle, so a pixel arriving on the same edge as
  // FVAL or LVAL rising gets the new frame/line coordinates immediately.
  always_comb begin
    state_next = state_reg;
    col_eff    = col_reg;
    row_eff    = row_reg;
    xph_eff    = xph_reg;
    yph_eff    = yph_reg;
    accept     = 1'b0;
    first_pix  = 1'b0;
    unique case (state_reg)
      S_SYNC: begin
        // Never start inside a frame that was already running.
        if (!iFVAL) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        col_eff = '0;
        // Only entered with FVAL low, so FVAL high here is its rising edge.
        if (iFVAL) begin
          state_next = S_LINE;
          row_eff    = '0;
          xph_eff    = iX_PHASE;
          yph_eff    = iY_PHASE;
          accept     = iLVAL;
          first_pix  = iLVAL;
        end
      end
      S_LINE: begin
        if (!iFVAL) begin
          state_next = S_WAIT;
        end else begin
          accept    = iLVAL;
          first_pix = iLVAL & sof_pend_reg;
          if (!iLVAL && lval_d_reg) begin
            state_next = S_HBLANK;
          end
        end
      end
      S_HBLANK: begin
        col_eff = '0;
        if (!iFVAL) begin
          state_next = S_WAIT;
        end else if (iLVAL) begin
          state_next = S_LINE;
          row_eff    = row_reg + ROW_W'(1);
          accept     = 1'b1;
        end
      end
      default: begin
        state_next = S_SYNC;
      end
    endcase
  end

  assign in_range = (col_eff < COL_MAX);
  assign pix_ok   = accept & in_range;
  assign ovf_hit  = accept & ~in_range;

  // --------------------------------------------------------------------------
  // Position counters and phase latches
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_reg      <= '0;
      row_reg      <= '0;
      xph_reg      <= 1'b0;
      yph_reg      <= 1'b0;
      sof_pend_reg <= 1'b0;
      lval_d_reg   <= 1'b0;
    end else begin
      lval_d_reg <= iLVAL;
      row_reg    <= row_eff;
      xph_reg    <= xph_eff;
      yph_reg    <= yph_eff;
      if (state_next != S_LINE) begin
        col_reg <= '0;
      end else if (pix_ok) begin
        col_reg <= col_eff + CW'(1);
      end else begin
        col_reg <= col_eff;  // holds at COL_MAX once saturated
      end
      // FVAL can rise before LVAL; remember that the first pixel is still due.
      if (state_reg == S_WAIT && iFVAL) begin
        sof_pend_reg <= ~iLVAL;
      end else if (accept) begin
        sof_pend_reg <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0 pixel source
  // --------------------------------------------------------------------------
`ifdef BAYER_TEST_PATTERN_EN
  assign pix_data = iTP_SEL ? DW'({6'(row_eff), 6'(col_eff)}) : iDATA;
`else
  assign pix_data = iDATA;
`endif

  // --------------------------------------------------------------------------
  // Line buffer: read and write the same column, old data comes out.
  // --------------------------------------------------------------------------
  bayer_line_ram #(
    .DW    (DW),
    .DEPTH (MAX_WIDTH),
    .AW    (AW)
  ) u_line_ram (
    .CLK     (CLK),
    .wr_en   (pix_ok),
    .wr_addr (col_eff[AW-1:0]),
    .wr_data (pix_data),
    .rd_addr (col_eff[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  // --------------------------------------------------------------------------
  // Sideband pipeline
  // --------------------------------------------------------------------------
  // Parities are zeroed for dropped/idle cycles so oX/oY read 0 without DVAL.
  assign x_in = pix_ok & bayer_parity(col_eff[0], xph_eff);
  assign y_in = pix_ok & bayer_parity(row_eff[0], yph_eff);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dval_pipe_reg <= '0;
      sof_pipe_reg  <= '0;
      x_pipe_reg    <= '0;
      y_pipe_reg    <= '0;
    end else begin
      dval_pipe_reg[1] <= pix_ok;
      sof_pipe_reg[1]  <= first_pix;
      x_pipe_reg[1]    <= x_in;
      y_pipe_reg[1]    <= y_in;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        dval_pipe_reg[i] <= dval_pipe_reg[i-1];
        sof_pipe_reg[i]  <= sof_pipe_reg[i-1];
        x_pipe_reg[i]    <= x_pipe_reg[i-1];
        y_pipe_reg[i]    <= y_pipe_reg[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data pipeline and status
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_data_reg   <= '0;
      s1_row0_reg   <= 1'b0;
      s1_ovf_reg    <= 1'b0;
      d0_reg        <= '0;
      d1_reg        <= '0;
      frame_cnt_reg <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      s1_data_reg <= pix_data;
      s1_row0_reg <= (row_eff == '0);
      s1_ovf_reg  <= ovf_hit;
      d1_reg      <= dval_pipe_reg[1] ? s1_data_reg : '0;
      // Row 0 would otherwise show the last line of the previous frame.
      d0_reg      <= (dval_pipe_reg[1] && !s1_row0_reg) ? ram_rd_data : '0;
      // Counter and overflow clear land on the same edge that raises oSOF.
      if (sof_pipe_reg[PIPE_LAT-1]) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
        ovf_reg       <= 1'b0;
      end else if (s1_ovf_reg) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign oD0        = d0_reg;
  assign oD1        = d1_reg;
  assign oX         = x_pipe_reg[PIPE_LAT];
  assign oY         = y_pipe_reg[PIPE_LAT];
  assign oDVAL      = dval_pipe_reg[PIPE_LAT];
  assign oSOF       = sof_pipe_reg[PIPE_LAT];
  assign oFRAME_CNT = frame_cnt_reg;
  assign oOVF       = ovf_reg;

endmodule

// File: tb/tb_bayer_line_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bayer_line_sequencer
// Directed bench for bayer_line_sequencer with an 8-pixel line buffer.
// Pixels are driven as 16*row+col; every driven cycle carries the output
// expected two cycles later, and the following cycle compares against it.
// ----------------------------------------------------------------------------
module tb_bayer_line_sequencer;

  localparam int MAXW = 8;

  logic        CLK;
  logic        RST_N;
  logic [11:0] iDATA;
  logic        iFVAL;
  logic        iLVAL;
  logic        iX_PHASE;
  logic        iY_PHASE;
`ifdef BAYER_TEST_PATTERN_EN
  logic        iTP_SEL;
`endif
  logic [11:0] oD0;
  logic [11:0] oD1;
  logic        oX;
  logic        oY;
  logic        oDVAL;
  logic        oSOF;
  logic [15:0] oFRAME_CNT;
  logic        oOVF;

  int          n_tests;
  int          n_fail;
  int          dval_seen;
  logic [15:0] exp_fc;

  // Expectation for the pixel driven on the previous step.
  logic        pend_v;
  logic [11:0] pend_d0;
  logic [11:0] pend_d1;
  logic        pend_x;
  logic        pend_y;
  logic        pend_sof;

  bayer_line_sequencer #(
    .DW        (12),
    .MAX_WIDTH (MAXW),
    .AW        (3)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .iDATA      (iDATA),
    .iFVAL      (iFVAL),
    .iLVAL      (iLVAL),
    .iX_PHASE   (iX_PHASE),
    .iY_PHASE   (iY_PHASE),
`ifdef BAYER_TEST_PATTERN_EN
    .iTP_SEL    (iTP_SEL),
`endif
    .oD0        (oD0),
    .oD1        (oD1),
    .oX         (oX),
    .oY         (oY),
    .oDVAL      (oDVAL),
    .oSOF       (oSOF),
    .oFRAME_CNT (oFRAME_CNT),
    .oOVF       (oOVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dval"}, oDVAL, 0);
    check_val({tag, "_sof"}, oSOF, 0);
    check_val({tag, "_d0"}, oD0, 0);
    check_val({tag, "_d1"}, oD1, 0);
    check_val({tag, "_x"}, oX, 0);
    check_val({tag, "_y"}, oY, 0);
    check_val({tag, "_fcnt"}, oFRAME_CNT, 0);
    check_val({tag, "_ovf"}, oOVF, 0);
  endtask

  // Drive one cycle, check the output of the previous cycle's pixel,
  // then record this cycle's expectation.
  task automatic step(input logic fv, input logic lv, input logic [11:0] din,
                      input logic ev, input logic [11:0] e0, input logic [11:0] e1,
                      input logic ex, input logic ey, input logic es);
    iFVAL = fv;
    iLVAL = lv;
    iDATA = din;
    @(posedge CLK);
    #1;
    check_val("dval", oDVAL, pend_v);
    check_val("sof", oSOF, pend_sof);
    if (pend_v) begin
      check_val("d1", oD1, pend_d1);
      check_val("d0", oD0, pend_d0);
      check_val("x", oX, pend_x);
      check_val("y", oY, pend_y);
      dval_seen++;
      $display("[TB] pix d1=%03h d0=%03h x=%0d y=%0d sof=%0d fcnt=%0d ovf=%0d",
               oD1, oD0, oX, oY, oSOF, oFRAME_CNT, oOVF);
    end
    if (pend_sof) begin
      check_val("fcnt_at_sof", oFRAME_CNT, exp_fc);
      check_val("ovf_at_sof", oOVF, 0);
    end
    pend_v   = ev;
    pend_d0  = e0;
    pend_d1  = e1;
    pend_x   = ex;
    pend_y   = ey;
    pend_sof = es;
  endtask

  task automatic idle(input logic fv, input int n);
    for (int k = 0; k < n; k++) begin
      step(fv, 1'b0, 12'h0, 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One frame of rows x cols pixels, two blank cycles per line, three
  // FVAL-low cycles after. lead=0 raises FVAL and LVAL together.
  task automatic send_frame(input int rows, input int cols, input logic xp, input logic yp,
                            input logic tog, input logic lead, input logic tp);
    logic [11:0] din, e0, e1;
    logic        ev, ex, ey, es;
    iX_PHASE = xp;
    iY_PHASE = yp;
`ifdef BAYER_TEST_PATTERN_EN
    iTP_SEL = tp;
`endif
    exp_fc = exp_fc + 16'd1;
    if (lead) idle(1'b1, 1);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        din = 12'(16 * r + c);
        e1  = tp ? 12'({6'(r), 6'(c)}) : din;
        if (r == 0) e0 = 12'h0;
        else        e0 = tp ? 12'({6'(r - 1), 6'(c)}) : 12'(16 * (r - 1) + c);
        ev = (c < MAXW);
        ex = c[0] ^ xp;
        ey = r[0] ^ yp;
        es = (r == 0) && (c == 0);
        step(1'b1, 1'b1, din, ev, e0, e1, ex, ey, es);
      end
      idle(1'b1, 2);
      if (tog && r == 0) begin
        iX_PHASE = ~xp;
        iY_PHASE = ~yp;
      end
    end
    idle(1'b0, 3);
    check_val("fcnt_end", oFRAME_CNT, exp_fc);
`ifdef BAYER_TEST_PATTERN_EN
    iTP_SEL = 1'b0;
`endif
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    dval_seen = 0;
    exp_fc    = 16'd0;
    pend_v    = 1'b0;
    pend_d0   = 12'h0;
    pend_d1   = 12'h0;
    pend_x    = 1'b0;
    pend_y    = 1'b0;
    pend_sof  = 1'b0;
    RST_N     = 1'b0;
    iFVAL     = 1'b1;
    iLVAL     = 1'b0;
    iDATA     = 12'h0;
    iX_PHASE  = 1'b0;
    iY_PHASE  = 1'b0;
`ifdef BAYER_TEST_PATTERN_EN
    iTP_SEL   = 1'b0;
`endif

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST_N = 1'b1;

    // Come out of reset inside a running frame: nothing may be output.
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, 1'b1, 12'(256 + c), 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
      end
      idle(1'b1, 2);
    end
    idle(1'b0, 3);
    $display("[TB] midframe start: dval_seen=%0d", dval_seen);
    check_val("midframe_no_dval", dval_seen, 0);

    // 4x4, phases 0: first SOF gives frame count 1.
    send_frame(4, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("ovf_clear", oOVF, 0);

    // Phases 1/1 at SOF, inputs flipped after row 0.
    send_frame(4, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // 10-pixel lines into an 8-deep buffer.
    dval_seen = 0;
    send_frame(2, 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("ovf_dval_cnt", dval_seen, 2 * MAXW);
    check_val("ovf_set", oOVF, 1);

    // FVAL and LVAL rise together; SOF clears the overflow flag.
    send_frame(2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ovf_cleared", oOVF, 0);

    // Reset in the middle of a line.
    iX_PHASE = 1'b0;
    iY_PHASE = 1'b0;
    exp_fc   = exp_fc + 16'd1;
    idle(1'b1, 1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 12'(80 + c), 1'b1, 12'h0, 12'(80 + c), c[0], 1'b0, (c == 0));
    end
    RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge CLK);
    #1;
    check_all_zero("rst_edge");
    RST_N    = 1'b1;
    pend_v   = 1'b0;
    pend_sof = 1'b0;
    exp_fc   = 16'd0;
    dval_seen = 0;
    for (int c = 3; c < 6; c++) begin
      step(1'b1, 1'b1, 12'(80 + c), 1'b0, 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b1, 2);
    idle(1'b0, 3);
    check_val("post_rst_no_dval", dval_seen, 0);
    send_frame(4, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef BAYER_TEST_PATTERN_EN
    // Generated pattern; pixel (3,5) must read 0x0C5.
    send_frame(4, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
